// File: rtl/switch_debounce_ctrl_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_ctrl_if
// Signal bundle between the switch debouncer and its user.
//
// Signals:
//   en        - global debounce enable
//   sw_raw    - raw asynchronous switch levels, bit i = channel i
//   sw_clean  - debounced level per channel
//   sw_rise   - one-cycle pulse when sw_clean[i] goes 0->1
//   sw_fall   - one-cycle pulse when sw_clean[i] goes 1->0
//   busy      - high while any channel is waiting for a level to settle
//   press_cnt - per-channel 8-bit press counter, byte i = channel i
//               (only when SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN is defined)
//
// Modports:
//   slave  - the debouncer side
//   master - the side that drives en/sw_raw and consumes the results
// -----------------------------------------------------------------------------
interface switch_debounce_ctrl_if #(
    parameter int unsigned N_CH = 4
);
    logic            en;
    logic [N_CH-1:0] sw_raw;
    logic [N_CH-1:0] sw_clean;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic            busy;

`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
    logic [8*N_CH-1:0] press_cnt;

    modport slave (
        input  en,
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output busy,
        output press_cnt
    );

    modport master (
        output en,
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  busy,
        input  press_cnt
    );
`else
    modport slave (
        input  en,
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output busy
    );

    modport master (
        output en,
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  busy
    );
`endif

endinterface

// File: rtl/switch_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// switch_debounce_ctrl
// Multi-channel switch debouncer. Each raw input is synchronised through two
// flops, then a per-channel FSM accepts a new level only after it has been
// seen on DEBOUNCE_CYC+1 consecutive synchronised samples. Accepted edges
// produce one-cycle rise/fall pulses aligned with the new sw_clean value.
//
// Parameters:
//   N_CH         - number of independent channels (1..8)
//   CNT_W        - width of each channel's stability counter
//   DEBOUNCE_CYC - stable samples beyond the first needed to accept a level
//                  (1..2^CNT_W-1)
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-low reset
//   bus - switch_debounce_ctrl_if.slave (en, sw_raw in; sw_clean, sw_rise,
//         sw_fall, busy [, press_cnt] out)
//
// Optional feature:
//   SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN - adds press_cnt, an 8-bit wrapping
//   count of accepted rising edges per channel.
// -----------------------------------------------------------------------------
module switch_debounce_ctrl #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEBOUNCE_CYC = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    switch_debounce_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Two-stage synchroniser; the FSM only ever looks at sync2_q.
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [N_CH-1:0] clean_q;
    logic [N_CH-1:0] clean_d;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_q;
    logic [N_CH-1:0] fall_d;
    logic            busy_w;

`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
    logic [7:0] press_q [N_CH];
`endif

    // Next-state logic for all channels. Disabling forces a waiting channel
    // back to the idle state that matches its current clean level, which
    // takes priority over a simultaneous acceptance.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            clean_d[i] = clean_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;

            case (state_q[i])
                IDLE_LOW: begin
                    if (sync2_q[i] && bus.en) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end

                WAIT_HIGH: begin
                    if (!bus.en || !sync2_q[i]) begin
                        state_d[i] = IDLE_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE_HIGH;
                        cnt_d[i]   = '0;
                        clean_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!sync2_q[i] && bus.en) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end

                WAIT_LOW: begin
                    if (!bus.en || sync2_q[i]) begin
                        state_d[i] = IDLE_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE_LOW;
                        cnt_d[i]   = '0;
                        clean_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end

                default: begin
                    state_d[i] = IDLE_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // All channel state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE_LOW;
                cnt_q[i]   <= '0;
`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
                press_q[i] <= '0;
`endif
            end
        end else begin
            sync1_q <= bus.sw_raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
                // Counts in the same cycle the rise pulse becomes visible.
                if (rise_d[i]) begin
                    press_q[i] <= press_q[i] + 8'd1;
                end
`endif
            end
        end
    end

    // busy is decoded straight from the registered states.
    always_comb begin
        busy_w = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (state_q[i] == WAIT_HIGH || state_q[i] == WAIT_LOW) begin
                busy_w = 1'b1;
            end
        end
    end

    assign bus.sw_clean = clean_q;
    assign bus.sw_rise  = rise_q;
    assign bus.sw_fall  = fall_q;
    assign bus.busy     = busy_w;

`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
    always_comb begin
        bus.press_cnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            bus.press_cnt[8*i +: 8] = press_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_ctrl
// Directed bench for switch_debounce_ctrl at default parameters
// (4 channels, DEBOUNCE_CYC = 50). Inputs change just after a rising edge;
// outputs are sampled 1 time unit after each rising edge. With the raw level
// changed before posedge #1, a new level is accepted on posedge #53.
// -----------------------------------------------------------------------------
module tb_switch_debounce_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    switch_debounce_ctrl_if #(.N_CH(4)) bus ();

    switch_debounce_ctrl #(
        .N_CH        (4),
        .CNT_W       (16),
        .DEBOUNCE_CYC(50)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and move to the sampling point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus.en     = 1'b1;
        bus.sw_raw = 4'b0000;
        #2;
        checks++;
        if (bus.sw_clean !== 4'b0000 || bus.sw_rise !== 4'b0000 ||
            bus.sw_fall !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state clean=%b rise=%b fall=%b busy=%b exp all 0",
                     bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.busy);
        end
`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
        checks++;
        if (bus.press_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_press_cnt got=%h exp=0", bus.press_cnt);
        end
`endif
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.sw_clean !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle clean=%b busy=%b exp 0000/0",
                     bus.sw_clean, bus.busy);
        end
    endtask

    task automatic test_clean_press();
        bus.sw_raw[0] = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            step();
            checks++;
            if (bus.sw_clean !== 4'b0000 || bus.sw_rise !== 4'b0000 ||
                bus.sw_fall !== 4'b0000) begin
                errors++;
                $display("FAIL press_quiet edge=%0d clean=%b rise=%b fall=%b exp 0000",
                         i, bus.sw_clean, bus.sw_rise, bus.sw_fall);
            end
            checks++;
            if (bus.busy !== (i >= 3)) begin
                errors++;
                $display("FAIL press_busy edge=%0d got=%b exp=%b", i, bus.busy, (i >= 3));
            end
        end
        step();
        checks++;
        if (bus.sw_clean !== 4'b0001 || bus.sw_rise !== 4'b0001 ||
            bus.sw_fall !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL press_accept clean=%b rise=%b fall=%b busy=%b exp 0001/0001/0000/0",
                     bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.busy);
        end
        step();
        checks++;
        if (bus.sw_clean !== 4'b0001 || bus.sw_rise !== 4'b0000) begin
            errors++;
            $display("FAIL press_pulse_end clean=%b rise=%b exp 0001/0000",
                     bus.sw_clean, bus.sw_rise);
        end
    endtask

    task automatic test_bounce();
        for (int seg = 0; seg < 20; seg++) begin
            bus.sw_raw[1] = (seg % 2 == 0);
            for (int c = 0; c < 10; c++) begin
                step();
                checks++;
                if (bus.sw_clean !== 4'b0001 || bus.sw_rise !== 4'b0000 ||
                    bus.sw_fall !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce_quiet seg=%0d clean=%b rise=%b fall=%b exp 0001/0000/0000",
                             seg, bus.sw_clean, bus.sw_rise, bus.sw_fall);
                end
            end
        end
        bus.sw_raw[1] = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            step();
            checks++;
            if (bus.sw_rise !== 4'b0000 || bus.sw_clean !== 4'b0001) begin
                errors++;
                $display("FAIL bounce_hold edge=%0d clean=%b rise=%b exp 0001/0000",
                         i, bus.sw_clean, bus.sw_rise);
            end
        end
        step();
        checks++;
        if (bus.sw_clean !== 4'b0011 || bus.sw_rise !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_accept clean=%b rise=%b exp 0011/0010",
                     bus.sw_clean, bus.sw_rise);
        end
    endtask

    task automatic test_release();
        bus.sw_raw[2] = 1'b1;
        repeat (53) step();
        checks++;
        if (bus.sw_clean !== 4'b0111 || bus.sw_rise !== 4'b0100) begin
            errors++;
            $display("FAIL release_setup clean=%b rise=%b exp 0111/0100",
                     bus.sw_clean, bus.sw_rise);
        end
        step();
        bus.sw_raw[2] = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            step();
            checks++;
            if (bus.sw_clean !== 4'b0111 || bus.sw_fall !== 4'b0000 ||
                bus.sw_rise !== 4'b0000) begin
                errors++;
                $display("FAIL release_quiet edge=%0d clean=%b rise=%b fall=%b exp 0111/0000/0000",
                         i, bus.sw_clean, bus.sw_rise, bus.sw_fall);
            end
        end
        step();
        checks++;
        if (bus.sw_clean !== 4'b0011 || bus.sw_fall !== 4'b0100 ||
            bus.sw_rise !== 4'b0000) begin
            errors++;
            $display("FAIL release_accept clean=%b rise=%b fall=%b exp 0011/0000/0100",
                     bus.sw_clean, bus.sw_rise, bus.sw_fall);
        end
        step();
        checks++;
        if (bus.sw_fall !== 4'b0000 || bus.sw_clean !== 4'b0011) begin
            errors++;
            $display("FAIL release_pulse_end clean=%b fall=%b exp 0011/0000",
                     bus.sw_clean, bus.sw_fall);
        end
    endtask

    task automatic test_enable();
        bus.sw_raw[3] = 1'b1;
        repeat (32) step();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_waiting busy got=%b exp=1", bus.busy);
        end
        bus.en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (bus.busy !== 1'b0 || bus.sw_rise !== 4'b0000 ||
                bus.sw_clean !== 4'b0011) begin
                errors++;
                $display("FAIL enable_off cyc=%0d busy=%b rise=%b clean=%b exp 0/0000/0011",
                         i, bus.busy, bus.sw_rise, bus.sw_clean);
            end
        end
        bus.en = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            checks++;
            if (bus.sw_rise !== 4'b0000 || bus.sw_clean !== 4'b0011 ||
                bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL enable_restart edge=%0d rise=%b clean=%b busy=%b exp 0000/0011/1",
                         i, bus.sw_rise, bus.sw_clean, bus.busy);
            end
        end
        step();
        checks++;
        if (bus.sw_rise !== 4'b1000 || bus.sw_clean !== 4'b1011) begin
            errors++;
            $display("FAIL enable_accept rise=%b clean=%b exp 1000/1011",
                     bus.sw_rise, bus.sw_clean);
        end
    endtask

    task automatic test_async_reset();
        bus.sw_raw[2] = 1'b1;
        repeat (42) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.sw_clean !== 4'b1011) begin
            errors++;
            $display("FAIL areset_pre busy=%b clean=%b exp 1/1011", bus.busy, bus.sw_clean);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.sw_clean !== 4'b0000 || bus.sw_rise !== 4'b0000 ||
            bus.sw_fall !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate clean=%b rise=%b fall=%b busy=%b exp all 0",
                     bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        // Every raw input is high, so all four channels re-debounce together.
        for (int i = 1; i <= 52; i++) begin
            step();
            checks++;
            if (bus.sw_rise !== 4'b0000 || bus.sw_fall !== 4'b0000 ||
                bus.sw_clean !== 4'b0000) begin
                errors++;
                $display("FAIL areset_no_stray edge=%0d rise=%b fall=%b clean=%b exp 0000",
                         i, bus.sw_rise, bus.sw_fall, bus.sw_clean);
            end
        end
        step();
        checks++;
        if (bus.sw_rise !== 4'b1111 || bus.sw_clean !== 4'b1111) begin
            errors++;
            $display("FAIL areset_all_rise rise=%b clean=%b exp 1111/1111",
                     bus.sw_rise, bus.sw_clean);
        end
    endtask

    task automatic test_back_to_back();
        step();
        bus.sw_raw = 4'b0000;
        repeat (52) step();
        checks++;
        if (bus.sw_fall !== 4'b0000 || bus.sw_clean !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_quiet fall=%b clean=%b exp 0000/1111", bus.sw_fall, bus.sw_clean);
        end
        step();
        checks++;
        if (bus.sw_fall !== 4'b1111 || bus.sw_rise !== 4'b0000 ||
            bus.sw_clean !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_all_fall fall=%b rise=%b clean=%b exp 1111/0000/0000",
                     bus.sw_fall, bus.sw_rise, bus.sw_clean);
        end
        step();
        checks++;
        if (bus.sw_fall !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse_end fall=%b busy=%b exp 0000/0", bus.sw_fall, bus.busy);
        end
    endtask

`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
    task automatic test_press_cnt();
        rst        = 1'b0;
        bus.sw_raw = 4'b0000;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int p = 0; p < 257; p++) begin
            bus.sw_raw[0] = 1'b1;
            repeat (55) step();
            bus.sw_raw[0] = 1'b0;
            repeat (55) step();
        end
        checks++;
        if (bus.press_cnt !== 32'h0000_0001) begin
            errors++;
            $display("FAIL press_cnt_wrap got=%h exp=00000001", bus.press_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_enable();
        test_async_reset();
        test_back_to_back();
`ifdef SWITCH_DEBOUNCE_CTRL_PRESS_CNT_EN
        test_press_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
